conv_maxabs_collect: RTL
========================

Name: conv_maxabs_collect

Overview:
- Upstream stage of the int8 requantizer.
- Accepts a serial stream of signed 32-bit convolution accumulator results and packs LANES of them into a parallel bank.
- Tracks the maximum absolute value of each group, then issues a one-cycle conv_finish pulse with the bank and max_abs held stable for the requantizer's two-cycle sample window.
- Back-pressures the producer while a group is being handed off.

Parameters:
- LANES, 16: values per group; the bank width is LANES*DATA_W.
- DATA_W, 32: signed width of each accumulator value.
- HOLD_CYCLES, 2: cycles after the pulse during which outputs stay frozen and in_ready=0. Minimum 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  producer has a value on in_data.
- in_data  in  DATA_W  signed accumulator value.
- in_last  in  1  marks the final value of a short group. Valid only with in_valid.
- in_ready  out  1  block can accept a value this cycle.
- q_flat  out  LANES*DATA_W  packed bank; lane i occupies bits [i*DATA_W +: DATA_W].
- max_abs  out  DATA_W  signed, positive max |value| of the last completed group, floored at 1.
- conv_finish  out  1  one-cycle pulse: q_flat and max_abs are valid.

Behaviour:
- Reset values: in_ready=1, q_flat=0, max_abs=1, conv_finish=0, lane counter=0, running max=0, state=COLLECT.
- Reset mid-operation discards any partial group. No pulse is issued for it.
- Accept: a value is accepted when in_valid && in_ready.
- States:
  - COLLECT: in_ready=1. On accept, the value is written to lane[cnt], cnt increments, and the running max updates.
    - If cnt==LANES-1 or in_last=1, the next state is PULSE.
  - PULSE: lasts 1 cycle. conv_finish=1, in_ready=0, then go to HOLD.
  - HOLD: lasts HOLD_CYCLES cycles (counter). conv_finish=0, in_ready=0.
    - On the final HOLD cycle: bank, running max and cnt are cleared to 0 at that edge, and the state returns to COLLECT.
- Output timing:
  - max_abs register loads on the accepting edge that enters PULSE, so it is valid in the same cycle conv_finish=1.
  - Loaded value is max(final running max incl. last value, 1).
  - q_flat and max_abs are stable from the PULSE cycle through the end of HOLD.
  - max_abs then holds until the next PULSE. q_flat reads 0 at the start of the next COLLECT.
- Short groups: lanes not written before in_last read 0.
  - in_last on lane LANES-1 is equivalent to a normal full group.
- Absolute value: |x| = x if x >= 0, else -x.
  - x = -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - Comparison is unsigned on the DATA_W-1 magnitude bits.
- All-zero group: max_abs=1 (division-by-zero guard for the requantizer).
- in_valid while in_ready=0: ignored. The producer must hold the value (standard valid/ready).
- in_last without in_valid: ignored.
- Latency: last value accepted at edge N gives conv_finish high in cycle N+1.
- Next accept is possible LANES... earliest at cycle N+2+HOLD_CYCLES.

Optional Feature:
- CONV_MAXABS_SATCNT_EN
  - Defined: adds output sat_cnt [15:0]. It increments (saturating at 16'hFFFF) on each accepted value equal to -2^(DATA_W-1). It resets to 0 only on rst_n.
  - Undefined: the port and counter are absent. Saturation of |x| still applies.

Test Plan:
- Full group: feed values 1,-2,3,...,-16 (alternating sign) with in_valid held high.
  - Expect conv_finish exactly one cycle after the 16th accept.
  - Expect q_flat lane 15 = -16 and max_abs=16.
  - Expect in_ready=0 for 3 cycles (PULSE plus 2 HOLD).
- Short group: 5 values {7,-100,3,0,50} with in_last on the 5th.
  - Expect lanes 0-4 to match, lanes 5-15 = 0, max_abs=100.
- All zeros: 16 zeros.
  - Expect max_abs=1 and q_flat=0 during the pulse.
- Saturation: one value 0x80000000 among small values.
  - Expect max_abs=0x7FFFFFFF, lane content 0x80000000.
  - With CONV_MAXABS_SATCNT_EN, expect sat_cnt=1.
- Back-pressure: hold in_valid high through the hand-off.
  - Expect no accepts during PULSE/HOLD.
  - Expect the first value of the next group to land in lane 0 with a fresh running max (a smaller max, e.g. 5, is reported as 5).
- Reset mid-group: assert rst_n low after 8 accepts.
  - Expect all outputs at reset values.
  - Expect the next 16-value group to produce a correct single pulse.

Source files
------------

// File: rtl/conv_maxabs_collect.sv
// conv_maxabs_collect: serial-to-parallel collector ahead of the int8 requantizer.
// Packs up to LANES signed accumulator values into a bank and tracks the group's
// maximum absolute value. It then pulses conv_finish and holds the bank and
// max_abs frozen for HOLD_CYCLES cycles while the producer is back-pressured.
//
// Optional build macro: CONV_MAXABS_SATCNT_EN adds a 16-bit saturating counter
// (sat_cnt) of accepted most-negative values.
module conv_maxabs_collect #(
  parameter int unsigned LANES       = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] q_flat,
  output logic [DATA_W-1:0]       max_abs,
`ifdef CONV_MAXABS_SATCNT_EN
  output logic [15:0]             sat_cnt,
`endif
  output logic                    conv_finish
);

  localparam int unsigned CntW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned MagW  = DATA_W - 1;

  localparam logic [CntW-1:0]   LastLane = CntW'(LANES - 1);
  localparam logic [HoldW-1:0]  LastHold = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DATA_W-1:0] MinNeg   = {1'b1, {MagW{1'b0}}};

  typedef enum logic [1:0] {
    StCollect,
    StPulse,
    StHold
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic [LANES*DATA_W-1:0] bank_q, bank_d;
  logic [MagW-1:0]         run_max_q, run_max_d;
  logic [DATA_W-1:0]       max_abs_q, max_abs_d;

  logic              accept;
  logic [DATA_W-1:0] neg_data;
  logic [MagW-1:0]   in_mag;
  logic [MagW-1:0]   grp_max;

  assign in_ready    = (state_q == StCollect);
  assign conv_finish = (state_q == StPulse);
  assign accept      = in_valid && in_ready;
  assign q_flat      = bank_q;
  assign max_abs     = max_abs_q;

  // Magnitude of the incoming value; the most-negative code saturates to all-ones.
  always_comb begin
    neg_data = -in_data;
    in_mag   = in_data[MagW-1:0];
    if (in_data[DATA_W-1]) begin
      if (in_data == MinNeg) begin
        in_mag = '1;
      end else begin
        in_mag = neg_data[MagW-1:0];
      end
    end
    grp_max = (in_mag > run_max_q) ? in_mag : run_max_q;
  end

  // Next-state: collect lanes, pulse once, then hold outputs before clearing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    bank_d    = bank_q;
    run_max_d = run_max_q;
    max_abs_d = max_abs_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          bank_d[cnt_q*DATA_W +: DATA_W] = in_data;
          cnt_d     = cnt_q + 1'b1;
          run_max_d = grp_max;
          if ((cnt_q == LastLane) || in_last) begin
            state_d = StPulse;
            // Floor at 1 so the requantizer never divides by zero.
            max_abs_d = (grp_max == '0) ? DATA_W'(1) : {1'b0, grp_max};
          end
        end
      end
      StPulse: begin
        state_d = StHold;
        hold_d  = '0;
      end
      StHold: begin
        if (hold_q == LastHold) begin
          state_d   = StCollect;
          hold_d    = '0;
          cnt_d     = '0;
          bank_d    = '0;
          run_max_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCollect;
      cnt_q     <= '0;
      hold_q    <= '0;
      bank_q    <= '0;
      run_max_q <= '0;
      max_abs_q <= DATA_W'(1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      bank_q    <= bank_d;
      run_max_q <= run_max_d;
      max_abs_q <= max_abs_d;
    end
  end

`ifdef CONV_MAXABS_SATCNT_EN
  logic [15:0] sat_cnt_q;

  // Count accepted most-negative values, sticking at the top code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
    end else if (accept && (in_data == MinNeg) && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule
